// File: rtl/buffered_mul_taint_param.sv
// Variable-latency multiplier feeding a variable-latency output buffer, with 1-bit taint shadows.
// Define CONST_TIME_EN to remove the data-dependent early-out and fast path.
module buffered_mul_taint_param #(
  parameter int WIDTH       = 4,
  parameter int MUL_LATENCY = 2,
  parameter int BUF_LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_valid_t,
  output logic               in_ready,
  output logic               in_ready_t,
  input  logic [WIDTH-1:0]   in_a,
  input  logic               in_a_t,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_b_t,
  output logic               out_valid,
  output logic               out_valid_t,
  input  logic               out_ready,
  input  logic               out_ready_t,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_result_t
);

  localparam int MAX_LAT = (MUL_LATENCY > BUF_LATENCY) ? MUL_LATENCY : BUF_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int PW      = 2 * WIDTH;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LATENCY);
  localparam logic [CNT_W-1:0] BUF_LAST = CNT_W'(BUF_LATENCY);

  localparam logic       MUL_IDLE = 1'b0;
  localparam logic       MUL_BUSY = 1'b1;
  localparam logic [1:0] BUF_IDLE = 2'd0;
  localparam logic [1:0] BUF_WAIT = 2'd1;
  localparam logic [1:0] BUF_HOLD = 2'd2;

  logic             mulState_q, mulState_d;
  logic [CNT_W-1:0] mulCnt_q, mulCnt_d;
  logic [WIDTH-1:0] mulA_q, mulA_d, mulB_q, mulB_d;
  logic [1:0]       bufState_q, bufState_d;
  logic [CNT_W-1:0] bufCnt_q, bufCnt_d;
  logic [PW-1:0]    bufData_q, bufData_d;
  logic             ctlT_q, ctlT_d, opT_q, opT_d;
  logic             mulDt_q, mulDt_d, bufDt_q, bufDt_d;

  logic          accept, mulDone, transfer, bufAdvance, bufHold;
  logic [PW-1:0] mulProd;

  assign mulProd  = {{WIDTH{1'b0}}, mulA_q} * {{WIDTH{1'b0}}, mulB_q};
  assign in_ready = (mulState_q == MUL_IDLE);
  assign accept   = in_valid && in_ready;
  assign bufHold  = (bufState_q == BUF_HOLD);

`ifdef CONST_TIME_EN
  assign mulDone     = (mulState_q == MUL_BUSY) && (mulCnt_q == MUL_LAST);
  assign bufAdvance  = (bufState_q == BUF_WAIT) && (bufCnt_q == BUF_LAST);
  assign in_ready_t  = ctlT_q;
  assign out_valid_t = ctlT_q;
`else
  // Completion time leaks operand zeroness only when the two paths differ in length.
  localparam logic LAT_DIFF = (MUL_LATENCY != BUF_LATENCY);
  assign mulDone     = (mulState_q == MUL_BUSY) &&
                       ((mulCnt_q == MUL_LAST) || (mulA_q == '0) || (mulB_q == '0));
  assign bufAdvance  = (bufState_q == BUF_WAIT) &&
                       ((bufData_q != '0) || (bufCnt_q == BUF_LAST));
  assign in_ready_t  = ctlT_q | (opT_q & LAT_DIFF);
  assign out_valid_t = ctlT_q | (opT_q & LAT_DIFF);
`endif

  assign transfer     = mulDone && (bufState_q == BUF_IDLE);
  assign out_valid    = bufHold;
  assign out_result   = bufHold ? bufData_q : '0;
  assign out_result_t = bufDt_q | ctlT_q;

  // Next-state logic for both FSMs and the taint shadows.
  always_comb begin
    mulState_d = mulState_q;
    mulCnt_d   = mulCnt_q;
    mulA_d     = mulA_q;
    mulB_d     = mulB_q;
    mulDt_d    = mulDt_q;
    bufState_d = bufState_q;
    bufCnt_d   = bufCnt_q;
    bufData_d  = bufData_q;
    bufDt_d    = bufDt_q;
    ctlT_d     = ctlT_q | (in_valid_t & in_ready) | (out_ready_t & bufHold);
    opT_d      = opT_q | (accept & (in_a_t | in_b_t));

    case (mulState_q)
      MUL_IDLE: if (accept) begin
        mulState_d = MUL_BUSY;
        mulCnt_d   = CNT_ONE;
        mulA_d     = in_a;
        mulB_d     = in_b;
        mulDt_d    = in_a_t | in_b_t;
      end
      default: begin
        if (transfer) mulState_d = MUL_IDLE;
        else if (!mulDone) mulCnt_d = mulCnt_q + CNT_ONE;
      end
    endcase

    case (bufState_q)
      BUF_IDLE: if (transfer) begin
        bufState_d = BUF_WAIT;
        bufCnt_d   = CNT_ONE;
        bufData_d  = mulProd;
        bufDt_d    = mulDt_q;
      end
      BUF_WAIT: begin
        if (bufAdvance) bufState_d = BUF_HOLD;
        else bufCnt_d = bufCnt_q + CNT_ONE;
      end
      BUF_HOLD: if (out_ready) bufState_d = BUF_IDLE;
      default: bufState_d = BUF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mulState_q <= MUL_IDLE;
      mulCnt_q   <= '0;
      mulA_q     <= '0;
      mulB_q     <= '0;
      mulDt_q    <= 1'b0;
      bufState_q <= BUF_IDLE;
      bufCnt_q   <= '0;
      bufData_q  <= '0;
      bufDt_q    <= 1'b0;
      ctlT_q     <= 1'b0;
      opT_q      <= 1'b0;
    end else begin
      mulState_q <= mulState_d;
      mulCnt_q   <= mulCnt_d;
      mulA_q     <= mulA_d;
      mulB_q     <= mulB_d;
      mulDt_q    <= mulDt_d;
      bufState_q <= bufState_d;
      bufCnt_q   <= bufCnt_d;
      bufData_q  <= bufData_d;
      bufDt_q    <= bufDt_d;
      ctlT_q     <= ctlT_d;
      opT_q      <= opT_d;
    end
  end

endmodule

// File: tb/tb_buffered_mul_taint_param.sv
// Directed bench for buffered_mul_taint_param: default instance plus a matched-latency instance.
// Expectations follow the build: CONST_TIME_EN selects the constant-latency numbers.
module tb_buffered_mul_taint_param;

`ifdef CONST_TIME_EN
  localparam bit CT = 1'b1;
`else
  localparam bit CT = 1'b0;
`endif
  localparam int LAT_NZ  = CT ? 6 : 4;
  localparam int LAT_Z   = CT ? 6 : 5;
  localparam int LAT2_NZ = CT ? 7 : 5;
  localparam logic OPV_T = CT ? 1'b0 : 1'b1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inValid = 1'b0, inValidT = 1'b0, outReady = 1'b1, outReadyT = 1'b0;
  logic [3:0] inA = '0, inB = '0;
  logic inAT = 1'b0, inBT = 1'b0;

  logic inReady, inReadyT, outValid, outValidT, outResultT;
  logic [7:0] outResult;
  logic inReady2, inReadyT2, outValid2, outValidT2, outResultT2;
  logic [7:0] outResult2;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  logic sawValid;

  buffered_mul_taint_param #(.WIDTH(4), .MUL_LATENCY(2), .BUF_LATENCY(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_valid_t(inValidT),
    .in_ready(inReady), .in_ready_t(inReadyT),
    .in_a(inA), .in_a_t(inAT), .in_b(inB), .in_b_t(inBT),
    .out_valid(outValid), .out_valid_t(outValidT),
    .out_ready(outReady), .out_ready_t(outReadyT),
    .out_result(outResult), .out_result_t(outResultT)
  );

  buffered_mul_taint_param #(.WIDTH(4), .MUL_LATENCY(3), .BUF_LATENCY(3)) dutEq (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_valid_t(inValidT),
    .in_ready(inReady2), .in_ready_t(inReadyT2),
    .in_a(inA), .in_a_t(inAT), .in_b(inB), .in_b_t(inBT),
    .out_valid(outValid2), .out_valid_t(outValidT2),
    .out_ready(outReady), .out_ready_t(outReadyT),
    .out_result(outResult2), .out_result_t(outResultT2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    inValid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic at, input logic bt, input logic ivt);
    inA = a;
    inB = b;
    inAT = at;
    inBT = bt;
    inValidT = ivt;
    inValid = 1'b1;
  endtask

  // Called in cycle 1; steps until out_valid (bounded) and returns the cycle it rose.
  task automatic waitValid(output int c);
    c = 1;
    while (!outValid && c < 30) begin
      step();
      c++;
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic at, input logic bt, input int expLat,
                       input logic [7:0] expRes, input logic expResT, input logic expVT,
                       output int endCycle);
    int c;
    applyStimulus(a, b, at, bt, 1'b0);
    checkOutput({tag, " in_ready"}, 32'(inReady), 32'd1);
    step();
    inValid = 1'b0;
    inAT = 1'b0;
    inBT = 1'b0;
    checkOutput({tag, " busy"}, 32'(inReady), 32'd0);
    checkOutput({tag, " in_ready_t c1"}, 32'(inReadyT), 32'(expVT));
    waitValid(c);
    checkOutput({tag, " latency"}, 32'(c), 32'(expLat));
    checkOutput({tag, " result"}, 32'(outResult), 32'(expRes));
    checkOutput({tag, " result_t"}, 32'(outResultT), 32'(expResT));
    checkOutput({tag, " valid_t"}, 32'(outValidT), 32'(expVT));
    step();
    checkOutput({tag, " drained"}, 32'(outValid), 32'd0);
    endCycle = c + 1;
  endtask

  initial begin
    int c;

    // Test 1: reset in the middle of a tainted operation
    resetDut();
    checkOutput("por in_ready", 32'(inReady), 32'd1);
    checkOutput("por out_valid", 32'(outValid), 32'd0);
    applyStimulus(4'd3, 4'd5, 1'b1, 1'b0, 1'b1);
    step();
    inValid = 1'b0;
    inValidT = 1'b0;
    inAT = 1'b0;
    checkOutput("t1 ctl taint set", 32'(inReadyT), 32'd1);
    step();
    resetDut();
    checkOutput("t1 in_ready", 32'(inReady), 32'd1);
    checkOutput("t1 out_valid", 32'(outValid), 32'd0);
    checkOutput("t1 out_result", 32'(outResult), 32'd0);
    checkOutput("t1 taints", {29'd0, inReadyT, outValidT, outResultT}, 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      sawValid = sawValid | outValid;
    end
    checkOutput("t1 no orphan result", 32'(sawValid), 32'd0);

    // Tests 2 and 3: untainted nonzero and zero-operand timing
    runOp("t2 3x5", 4'd3, 4'd5, 1'b0, 1'b0, LAT_NZ, 8'd15, 1'b0, 1'b0, c);
    runOp("t3 0x7", 4'd0, 4'd7, 1'b0, 1'b0, LAT_Z, 8'd0, 1'b0, 1'b0, c);
    runOp("t3 7x0", 4'd7, 4'd0, 1'b0, 1'b0, LAT_Z, 8'd0, 1'b0, 1'b0, c);
    runOp("t3 15x15", 4'd15, 4'd15, 1'b0, 1'b0, LAT_NZ, 8'd225, 1'b0, 1'b0, c);

    // Test 4: tainted operand; matched-latency instance must not taint out_valid
    resetDut();
    runOp("t4 3x5 a_t", 4'd3, 4'd5, 1'b1, 1'b0, LAT_NZ, 8'd15, 1'b1, OPV_T, c);
    checkOutput("t4 sticky in_ready_t", 32'(inReadyT), 32'(OPV_T));
    while (!outValid2 && c < 30) begin
      step();
      c++;
    end
    checkOutput("t4 eq latency", 32'(c), 32'(LAT2_NZ));
    checkOutput("t4 eq result", 32'(outResult2), 32'd15);
    checkOutput("t4 eq result_t", 32'(outResultT2), 32'd1);
    checkOutput("t4 eq valid_t", 32'(outValidT2), 32'd0);
    checkOutput("t4 eq in_ready_t", 32'(inReadyT2), 32'd0);

    // Test 5: back-pressure stalls the multiplier behind a held result
    resetDut();
    outReady = 1'b0;
    applyStimulus(4'd2, 4'd2, 1'b0, 1'b0, 1'b0);
    step();
    inValid = 1'b0;
    waitValid(c);
    checkOutput("t5 first latency", 32'(c), 32'(LAT_NZ));
    checkOutput("t5 first result", 32'(outResult), 32'd4);
    applyStimulus(4'd1, 4'd3, 1'b0, 1'b0, 1'b0);
    checkOutput("t5 second accept", 32'(inReady), 32'd1);
    step();
    inValid = 1'b0;
    step();
    step();
    step();
    checkOutput("t5 hold valid", 32'(outValid), 32'd1);
    checkOutput("t5 hold result", 32'(outResult), 32'd4);
    checkOutput("t5 mul stalled", 32'(inReady), 32'd0);
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    checkOutput("t5 handoff in_ready", 32'(inReady), 32'd0);
    waitValid(c);
    checkOutput("t5 second latency", 32'(c), CT ? 32'd5 : 32'd3);
    checkOutput("t5 second result", 32'(outResult), 32'd3);
    outReady = 1'b1;
    step();
    checkOutput("t5 drained", 32'(outValid), 32'd0);

    // Test 6: constant-time comparison of a zero and a tainted nonzero operand
    resetDut();
    runOp("t6 0x5", 4'd0, 4'd5, 1'b0, 1'b0, LAT_Z, 8'd0, 1'b0, 1'b0, c);
    runOp("t6 3x5 a_t", 4'd3, 4'd5, 1'b1, 1'b0, LAT_NZ, 8'd15, 1'b1, OPV_T, c);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
